// File: rtl/aes_pkg.sv
// Shared constants and the loader state encoding for the AES input feeder.
package aes_pkg;

  localparam int AES_BLK_W         = 128;
  localparam int AES_WORD_W        = 32;
  localparam int AES_WORDS_PER_BLK = AES_BLK_W / AES_WORD_W;

  // state     | meaning
  // LOAD_KEY  | shifting in key words (MSW first), s_ready=1
  // LOAD_DATA | shifting in plaintext words (MSW first), s_ready=1
  // RUN       | AES_en high, operands frozen, waiting for the core
  // GAP       | one idle cycle that forces AES_en low between blocks
  typedef enum logic [1:0] {
    LOAD_KEY  = 2'd0,
    LOAD_DATA = 2'd1,
    RUN       = 2'd2,
    GAP       = 2'd3
  } loader_state_e;

endpackage

// File: rtl/aes_run_watchdog.sv
// RUN-phase watchdog: counts RUN cycles and latches a sticky timeout flag
// when the core fails to report completion within TIMEOUT_CYC cycles.
module aes_run_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic done,
  output logic expire,
  output logic timeout_err
);

  localparam logic [15:0] LAST_CYC = 16'(TIMEOUT_CYC - 1);

  logic [15:0] timer;

  // Last allowed RUN cycle; the FSM leaves RUN on the following edge.
  assign expire = en & (timer == LAST_CYC);

  // RUN cycle counter, held at zero outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timer <= '0;
    else if (clr)
      timer <= '0;
    else if (en)
      timer <= timer + 16'd1;
  end

  // Sticky error; a completion in the expiring cycle takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timeout_err <= 1'b0;
    else if (expire && !done)
      timeout_err <= 1'b1;
  end

endmodule

// File: rtl/aes_in_loader.sv
// Word-stream to AES_top feeder: assembles key and plaintext from 32-bit
// words, drives AES_en until the core completes, counts finished blocks.
// Optional key reuse (key_keep port) is enabled by AES_LOADER_KEY_REUSE_EN.
module aes_in_loader
  import aes_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic                 AES_clk,
  input  logic                 AES_rst,
`ifdef AES_LOADER_KEY_REUSE_EN
  input  logic                 key_keep,
`endif
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_W-1:0]    s_data,
  input  logic                 AES_data_out_valid,
  output logic                 AES_en,
  output logic [AES_BLK_W-1:0] AES_key_in,
  output logic [AES_BLK_W-1:0] AES_data_in,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     blk_cnt
);

  loader_state_e state;
  logic [1:0]    idx;
  logic          xfer;
  logic          last_word;
  logic          key_skip;
  logic          expire;

  assign s_ready   = (state == LOAD_KEY) || (state == LOAD_DATA);
  assign busy      = (state == RUN) || (state == GAP);
  assign xfer      = s_valid & s_ready;
  assign last_word = (idx == 2'(AES_WORDS_PER_BLK - 1));

  // A kept key turns the first frame word into plaintext word 0.
`ifdef AES_LOADER_KEY_REUSE_EN
  assign key_skip = key_keep & (idx == 2'd0);
`else
  assign key_skip = 1'b0;
`endif

  aes_run_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk         (AES_clk),
    .rst         (AES_rst),
    .clr         (state != RUN),
    .en          (state == RUN),
    .done        (AES_data_out_valid),
    .expire      (expire),
    .timeout_err (timeout_err)
  );

  // Loader FSM with key/plaintext shift registers and block counter.
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state       <= LOAD_KEY;
      idx         <= 2'd0;
      AES_en      <= 1'b0;
      AES_key_in  <= '0;
      AES_data_in <= '0;
      blk_cnt     <= '0;
    end else begin
      case (state)
        LOAD_KEY: begin
          if (xfer) begin
            if (key_skip) begin
              AES_data_in <= {AES_data_in[AES_BLK_W-WORD_W-1:0], s_data};
              idx         <= 2'd1;
              state       <= LOAD_DATA;
            end else begin
              AES_key_in <= {AES_key_in[AES_BLK_W-WORD_W-1:0], s_data};
              idx        <= idx + 2'd1;
              if (last_word)
                state <= LOAD_DATA;
            end
          end
        end
        LOAD_DATA: begin
          if (xfer) begin
            AES_data_in <= {AES_data_in[AES_BLK_W-WORD_W-1:0], s_data};
            idx         <= idx + 2'd1;
            if (last_word) begin
              state  <= RUN;
              AES_en <= 1'b1;
            end
          end
        end
        RUN: begin
          if (AES_data_out_valid) begin
            AES_en  <= 1'b0;
            blk_cnt <= blk_cnt + CNT_W'(1);
            state   <= GAP;
          end else if (expire) begin
            AES_en <= 1'b0;
            state  <= GAP;
          end
        end
        GAP: begin
          state <= LOAD_KEY;
        end
        default: begin
          state  <= LOAD_KEY;
          AES_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_in_loader.sv
// Directed bench for aes_in_loader: one instance with the default watchdog
// and one with TIMEOUT_CYC=20 for the timeout scenarios.
module tb_aes_in_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic [31:0]  s_data = '0;
  logic         key_keep = 1'b0;
  logic         core_vld = 1'b0;
  logic         core_vld_t = 1'b0;

  logic         rdy, en, busy, terr;
  logic [127:0] key, dat;
  logic [15:0]  blk;
  logic         rdy_t, en_t, busy_t, terr_t;
  logic [127:0] key_t, dat_t;
  logic [15:0]  blk_t;

  int checks = 0;
  int errors = 0;
  int cnt;

  localparam logic [127:0] KEY_A = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] DAT_A = 128'h00000065_00000000_00000000_00000000;
  localparam logic [127:0] DAT_B = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;

  always #5 clk = ~clk;

  aes_in_loader dut (
    .AES_clk (clk), .AES_rst (rst),
`ifdef AES_LOADER_KEY_REUSE_EN
    .key_keep (key_keep),
`endif
    .s_valid (s_valid), .s_ready (rdy), .s_data (s_data),
    .AES_data_out_valid (core_vld), .AES_en (en),
    .AES_key_in (key), .AES_data_in (dat),
    .busy (busy), .timeout_err (terr), .blk_cnt (blk)
  );

  aes_in_loader #(.TIMEOUT_CYC(20)) dut_t (
    .AES_clk (clk), .AES_rst (rst),
`ifdef AES_LOADER_KEY_REUSE_EN
    .key_keep (key_keep),
`endif
    .s_valid (s_valid), .s_ready (rdy_t), .s_data (s_data),
    .AES_data_out_valid (core_vld_t), .AES_en (en_t),
    .AES_key_in (key_t), .AES_data_in (dat_t),
    .busy (busy_t), .timeout_err (terr_t), .blk_cnt (blk_t)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_word(input bit sel, input logic [31:0] d);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!(sel ? rdy_t : rdy) && n < 100) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    if (n == 100) check("ready_wait", 128'(n), 128'd0);
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    s_data  = 32'hdead_beef;
  endtask

  task automatic send_frame(input bit sel);
    send_word(sel, 32'haa2bdb40); send_word(sel, 32'hbff6a5e8);
    send_word(sel, 32'hcaa9ba3e); send_word(sel, 32'hbc1e2acc);
    send_word(sel, 32'h00000065); send_word(sel, 32'h0);
    send_word(sel, 32'h0);        send_word(sel, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_en", 128'(en), 128'd0);
    check("rst_key", key, 128'd0);
    check("rst_dat", dat, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_terr", 128'(terr), 128'd0);
    check("rst_blk", 128'(blk), 128'd0);
    check("rst_ready", 128'(rdy), 128'd1);

    // Basic back-to-back load
    send_word(0, 32'haa2bdb40); send_word(0, 32'hbff6a5e8);
    send_word(0, 32'hcaa9ba3e); send_word(0, 32'hbc1e2acc);
    check("basic_key", key, KEY_A);
    check("basic_en_keyphase", 128'(en), 128'd0);
    send_word(0, 32'h00000065); send_word(0, 32'h0); send_word(0, 32'h0);
    check("basic_en_before_last", 128'(en), 128'd0);
    send_word(0, 32'h0);
    check("basic_en_rise", 128'(en), 128'd1);
    check("basic_dat", dat, DAT_A);
    check("basic_busy_run", 128'(busy), 128'd1);
    check("basic_ready_run", 128'(rdy), 128'd0);
    repeat (49) @(posedge clk);
    @(negedge clk);
    check("basic_en_cyc50", 128'(en), 128'd1);
    check("basic_key_frozen", key, KEY_A);
    core_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    core_vld = 1'b0;
    check("basic_en_fall", 128'(en), 128'd0);
    check("basic_blk", 128'(blk), 128'd1);
    check("basic_gap_ready", 128'(rdy), 128'd0);
    check("basic_gap_busy", 128'(busy), 128'd1);
    @(posedge clk); @(negedge clk);
    check("basic_ready_back", 128'(rdy), 128'd1);
    check("basic_busy_idle", 128'(busy), 128'd0);
    core_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    core_vld = 1'b0;
    check("stray_valid_blk", 128'(blk), 128'd1);
    check("stray_valid_ready", 128'(rdy), 128'd1);

    // Stalled source: s_valid alternates, garbage data on idle cycles
    send_word(0, 32'haa2bdb40);
    check("stall_key_w0", key, 128'hbff6a5e8_caa9ba3e_bc1e2acc_aa2bdb40);
    s_data = 32'h1234_5678;
    @(posedge clk); @(negedge clk);
    check("stall_key_hold", key, 128'hbff6a5e8_caa9ba3e_bc1e2acc_aa2bdb40);
    send_word(0, 32'hbff6a5e8);
    @(posedge clk); @(negedge clk);
    send_word(0, 32'hcaa9ba3e);
    @(posedge clk); @(negedge clk);
    send_word(0, 32'hbc1e2acc);
    @(posedge clk); @(negedge clk);
    check("stall_key", key, KEY_A);
    send_word(0, 32'h00000065);
    @(posedge clk); @(negedge clk);
    send_word(0, 32'h0);
    @(posedge clk); @(negedge clk);
    send_word(0, 32'h0);
    @(posedge clk); @(negedge clk);
    check("stall_en_before_last", 128'(en), 128'd0);
    check("stall_dat_partial", dat, 128'h00000000_00000065_00000000_00000000);
    send_word(0, 32'h0);
    check("stall_en_rise", 128'(en), 128'd1);
    check("stall_dat", dat, DAT_A);
    core_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    core_vld = 1'b0;
    check("stall_blk", 128'(blk), 128'd2);
    @(posedge clk); @(negedge clk);

    // Reset mid-RUN
    send_frame(0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midrun_en_pre", 128'(en), 128'd1);
    rst = 1'b1;
    #1;
    check("midrun_en", 128'(en), 128'd0);
    check("midrun_key", key, 128'd0);
    check("midrun_dat", dat, 128'd0);
    check("midrun_busy", 128'(busy), 128'd0);
    check("midrun_blk", 128'(blk), 128'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrun_ready_after", 128'(rdy), 128'd1);
    check("midrun_en_after", 128'(en), 128'd0);

    // Timeout with TIMEOUT_CYC=20
    do_reset();
    send_frame(1);
    cnt = 0;
    while (en_t && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("to_en_cycles", 128'(cnt), 128'd20);
    check("to_terr", 128'(terr_t), 128'd1);
    check("to_blk", 128'(blk_t), 128'd0);
    check("to_gap_ready", 128'(rdy_t), 128'd0);
    @(posedge clk); @(negedge clk);
    check("to_ready_back", 128'(rdy_t), 128'd1);
    send_frame(1);
    check("to_reload_en", 128'(en_t), 128'd1);
    check("to_terr_sticky", 128'(terr_t), 128'd1);

    // Valid in the same cycle the watchdog expires
    do_reset();
    send_frame(1);
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("sim_en_cyc20", 128'(en_t), 128'd1);
    core_vld_t = 1'b1;
    @(posedge clk); @(negedge clk);
    core_vld_t = 1'b0;
    check("sim_terr", 128'(terr_t), 128'd0);
    check("sim_blk", 128'(blk_t), 128'd1);
    check("sim_en_fall", 128'(en_t), 128'd0);

`ifdef AES_LOADER_KEY_REUSE_EN
    // Key reuse: full frame, then a 4-word frame with key_keep
    do_reset();
    send_frame(0);
    core_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    core_vld = 1'b0;
    @(posedge clk); @(negedge clk);
    key_keep = 1'b1;
    send_word(0, 32'ha6f2daeb);
    key_keep = 1'b0;
    send_word(0, 32'h140fa720);
    send_word(0, 32'h529e75d5);
    check("reuse_en_before_last", 128'(en), 128'd0);
    send_word(0, 32'h21cbc681);
    check("reuse_en_rise", 128'(en), 128'd1);
    check("reuse_key", key, KEY_A);
    check("reuse_dat", dat, DAT_B);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_in_loader.md
Name: aes_in_loader

Overview:
Upstream feeder for AES_top. It accepts a 32-bit word stream over a valid/ready handshake and assembles a 128-bit key and a 128-bit plaintext, MSW first. It then drives AES_en, AES_key_in and AES_data_in, and holds them stable until the core reports AES_data_out_valid. A watchdog and a completed-block counter support bring-up and verification.

Parameters:
- WORD_W, 32, input word width; fixed at 32 (128/WORD_W = 4 words per block).
- TIMEOUT_CYC, 255, maximum RUN cycles allowed without AES_data_out_valid; legal range 2..65535.
- CNT_W, 16, width of blk_cnt.

Ports:
- AES_clk  in  1  clock, rising edge.
- AES_rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  input word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  WORD_W  input word.
- AES_data_out_valid  in  1  core completion pulse.
- AES_en  out  1  core enable, held high for the whole operation.
- AES_key_in  out  128  key to core.
- AES_data_in  out  128  plaintext to core.
- busy  out  1  high in RUN and GAP.
- timeout_err  out  1  sticky watchdog flag.
- blk_cnt  out  CNT_W  count of completed blocks.

Behaviour:
- Reset (async, active-high): state=LOAD_KEY, all outputs 0 including AES_key_in and AES_data_in, word index=0, timer=0. AES_en must drop in the same cycle reset asserts (reset mid-RUN aborts the operation).
- Handshake: a word transfers on a rising edge where s_valid & s_ready. s_ready is combinational from state only: 1 in LOAD_KEY and LOAD_DATA, 0 otherwise. s_data is ignored when no transfer occurs.
- LOAD_KEY: on each transfer, AES_key_in <= {AES_key_in[95:0], s_data}; the 2-bit word index increments. After the 4th transfer, index wraps to 0 and state goes to LOAD_DATA.
- LOAD_DATA: on each transfer, AES_data_in <= {AES_data_in[95:0], s_data}. On the 4th transfer, state goes to RUN and AES_en<=1 at the same edge, so AES_en is high in the cycle after the last data handshake. Timer is cleared.
- RUN: AES_en=1, and AES_key_in and AES_data_in are frozen. The timer increments each cycle.
  - AES_data_out_valid=1: AES_en<=0, blk_cnt<=blk_cnt+1 (wraps modulo 2^CNT_W), state goes to GAP.
  - No valid and timer==TIMEOUT_CYC-1: AES_en<=0, timeout_err<=1, blk_cnt unchanged, state goes to GAP.
  - Valid and timeout in the same cycle: valid wins, and timeout_err is not set.
- GAP: exactly 1 cycle with AES_en=0 and s_ready=0, then LOAD_KEY. This guarantees at least one low cycle of AES_en between blocks.
- AES_data_out_valid outside RUN is ignored (no count, no state change).
- timeout_err is cleared only by reset.
- busy = (state==RUN) | (state==GAP).
- Minimum block period: 8 load cycles + RUN length + 1 GAP cycle.

Optional Feature:
- Macro AES_LOADER_KEY_REUSE_EN.
- Defined:
  - Adds input port key_keep (1 bit), sampled together with the 1st word of a frame, with word index 0, in LOAD_KEY.
  - If key_keep=1 on that transfer, the word is taken as data word 0: it shifts into AES_data_in and state jumps to LOAD_DATA with index=1.
  - AES_key_in retains its previous value, so a frame is 4 words.
  - After reset, the key is 0 until a full key is loaded.
- Undefined: no key_keep port; every frame is exactly 8 words.

Decomposition:
- Package aes_pkg holds:
  - AES_BLK_W=128, AES_WORD_W=32, AES_WORDS_PER_BLK=4;
  - loader state enum {LOAD_KEY, LOAD_DATA, RUN, GAP} with 2-bit encoding 0..3.
- One natural sub-module, aes_run_watchdog: timer, TIMEOUT compare and sticky timeout_err, with clear/enable inputs from the FSM.
- Shift registers and the FSM stay in aes_in_loader.

Test Plan:
- Basic load: send key words aa2bdb40, bff6a5e8, caa9ba3e, bc1e2acc, then data words 00000065, 0, 0, 0, back-to-back.
  - AES_key_in must equal aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc and AES_data_in must equal 00000065_00000000_00000000_00000000.
  - AES_en must rise 1 cycle after the 8th handshake.
  - A stub core pulses valid after 50 cycles: AES_en falls the next edge, blk_cnt=1, s_ready returns after 1 GAP cycle.
- Stalled source: s_valid toggles 1/0 each cycle.
  - Same final registers as the basic load.
  - No extra shifts on cycles where s_valid=0.
  - AES_en stays 0 until the 8th transfer.
- Timeout: with TIMEOUT_CYC=20, the stub never asserts valid.
  - AES_en is high for exactly 20 cycles, then timeout_err=1 stays high, blk_cnt=0, and the loader accepts a new frame.
- Simultaneous valid and timeout: valid arrives in the 20th RUN cycle.
  - timeout_err stays 0 and blk_cnt increments.
- Reset mid-RUN: assert AES_rst 10 cycles into RUN.
  - AES_en, AES_key_in, AES_data_in, busy and blk_cnt are 0 immediately.
  - State is LOAD_KEY after release.
- AES_LOADER_KEY_REUSE_EN: load a full frame, then a frame with key_keep=1 and data a6f2daeb, 140fa720, 529e75d5, 21cbc681.
  - AES_key_in is unchanged.
  - AES_data_in=a6f2daeb_140fa720_529e75d5_21cbc681.
  - AES_en rises after the 4th word.
